icache_assoc: RTL and testbench
===============================

# icache_assoc

Parametrised N-way set-associative instruction cache with true-LRU replacement and multi-word blocks. It is the next-generation replacement for the fixed direct-mapped icache inside the caches wrapper. It sits between the datapath fetch port (imemREN/imemaddr/ihit/imemload) and the memory-controller instruction port (iREN/iaddr/iwait/iload). Over the old block it adds configurable associativity, set count and block size, a bulk invalidate, and hit/miss counters.

## Interface
- WAYS, 2: associativity; 1, 2 or 4.
- SETS, 8: number of sets; power of two, ≥2.
- BLKWORDS, 2: 32-bit words per block; 1, 2 or 4.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- imemREN  in  1  fetch request from the datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- inval  in  1  invalidate all lines (single-cycle pulse).
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  fetched instruction; 0 when ihit=0.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, always word-aligned.
- iwait  in  1  memory busy; iload is valid the cycle iwait=0 while iREN=1.
- iload  in  32  memory read data.
- hitcnt  out  32  count of ihit cycles.
- misscnt  out  32  count of misses (fills started).

## Operation
- Address split: [1:0] byte offset; next log2(BLKWORDS) bits are the word offset; next log2(SETS) bits are the index; remaining high bits are the tag.
- Per way and set: valid bit, tag, BLKWORDS data words, and an LRU age of log2(WAYS) bits. Ages within a set always form a permutation of 0..WAYS-1.
- States: IDLE and FETCH.
- IDLE:
  - Hit means imemREN=1 and some way at the index is valid with a matching tag.
  - On a hit: ihit=1 and imemload = the addressed word, combinationally. LRU update on the clock edge: the hit way's age becomes 0; ways with a smaller age each increment by 1.
  - On a miss (imemREN=1, no hit): latch tag and index, reset word count wc=0, and choose a victim. The victim is the lowest-numbered invalid way; if all ways are valid, it is the way with age WAYS-1. Increment misscnt and go to FETCH.
- FETCH:
  - Drive iREN=1 and iaddr = {latched tag, latched index, wc, 2'b00}.
  - When iwait=0: write iload into the victim way at word wc, then increment wc.
  - When the word with wc = BLKWORDS-1 is accepted: set the victim's valid bit and tag, apply the LRU update for the victim way, and return to IDLE.
  - The fill always completes for the latched address, even if imemREN or imemaddr changes meanwhile. ihit=0 throughout FETCH.
- inval:
  - In IDLE it clears every valid bit on that edge and ihit is forced to 0 in the same cycle.
  - In FETCH it is latched as pending. On the completing edge the fill data is written but the line is not marked valid, and all valid bits are cleared. The pending flag then clears.
  - LRU ages are never changed by inval.
- hitcnt increments on every cycle with ihit=1. Both counters wrap modulo 2^32.

## Timing
- Reset values (asynchronous): state IDLE, all valid bits 0, age[w]=w in every set, wc=0, pending-inval 0. Outputs: ihit=0, imemload=0, iREN=0, iaddr=0, hitcnt=0, misscnt=0.
- Hit latency: 0 cycles; ihit is combinational from imemaddr in IDLE.
- Miss with zero-wait memory, detected at cycle t: iREN=1 in cycles t+1..t+BLKWORDS, and ihit=1 at t+BLKWORDS+1 if the request is held. Each iwait=1 cycle adds one cycle.
- iREN is deasserted in the cycle after the last word is accepted.
- If RST is asserted during FETCH: immediate return to IDLE, partial line discarded, iREN=0 asynchronously.
- Requests with imemREN=0 never hit, never miss and never change LRU state.

## Test plan
- Cold miss with BLKWORDS=2, iwait=0, address 0x40: iaddr=0x40 then 0x44. The next cycle has ihit=1, imemload=mem[0x40], misscnt=1. Then address 0x44 gives an immediate ihit with mem[0x44] and hitcnt=2.
- WAYS=2, SETS=8, BLKWORDS=2; fill addresses 0x000 and 0x040 (same index), re-hit 0x000, then miss 0x080. The 0x040 line is evicted: 0x000 still hits and 0x040 misses again.
- iwait held at 1 for 3 cycles per word: iaddr stays stable while waiting, and the fill takes 8 cycles for BLKWORDS=2 before ihit.
- inval pulsed mid-fill of 0x100: the fill completes, but the re-request of 0x100 misses. misscnt increments twice.
- inval pulsed in IDLE after warm hits: ihit=0 in that cycle and on the next request. LRU order is preserved, verified by the next eviction choice.
- RST asserted mid-FETCH: iREN=0 immediately, counters=0, and the first request afterwards misses.

Source files
------------

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with true-LRU replacement, multi-word
// blocks, bulk invalidate and hit/miss counters.
module icache_assoc #(
   parameter int WAYS     = 2,
   parameter int SETS     = 8,
   parameter int BLKWORDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        inval,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hitcnt,
   output logic [31:0] misscnt
);

   localparam int OB  = $clog2(BLKWORDS);
   localparam int IB  = $clog2(SETS);
   localparam int TW  = 30 - OB - IB;
   localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WOB = (OB > 0) ? OB : 1;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t          state;
   logic [WOB-1:0]  wc;
   logic [TW-1:0]   l_tag;
   logic [IB-1:0]   l_idx;
   logic [AW-1:0]   victim_r;
   logic            pend_inval;

   logic [WAYS-1:0] valid [SETS];
   logic [AW-1:0]   age   [SETS][WAYS];
   logic [TW-1:0]   tags  [SETS][WAYS];
   logic [31:0]     data  [SETS][WAYS][BLKWORDS];

   logic [IB-1:0]   cur_idx;
   logic [TW-1:0]   cur_tag;
   logic [WOB-1:0]  cur_word;
   logic            match;
   logic [AW-1:0]   hit_way;
   logic            any_invalid;
   logic [AW-1:0]   victim;
   logic            lookup_ok;
   logic            miss;
   logic            accept;
   logic            fill_done;
   logic            touch_en;
   logic [IB-1:0]   touch_set;
   logic [AW-1:0]   touch_way;

   assign cur_idx  = imemaddr[OB+2 +: IB];
   assign cur_tag  = imemaddr[31 -: TW];
   assign cur_word = imemaddr[2 +: WOB] & WOB'(BLKWORDS - 1);

   // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
   always_comb begin
      match   = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[cur_idx][w] && tags[cur_idx][w] == cur_tag) begin
            match   = 1'b1;
            hit_way = AW'(w);
         end
      end
   end

   // Lowest-numbered invalid way wins; otherwise the oldest way is replaced.
   always_comb begin
      victim      = '0;
      any_invalid = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[cur_idx][w]) begin
            victim      = AW'(w);
            any_invalid = 1'b1;
         end
      end
      if (!any_invalid) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age[cur_idx][w] == AW'(WAYS - 1)) victim = AW'(w);
         end
      end
   end

   // An invalidate in IDLE suppresses the lookup for that cycle entirely.
   assign lookup_ok = (state == IDLE) && imemREN && !inval;
   assign ihit      = lookup_ok && match;
   assign miss      = lookup_ok && !match;
   assign imemload  = ihit ? data[cur_idx][hit_way][cur_word] : 32'd0;

   assign accept    = (state == FETCH) && !iwait;
   assign fill_done = accept && (wc == WOB'(BLKWORDS - 1));

   assign touch_en  = ihit || fill_done;
   assign touch_set = (state == FETCH) ? l_idx : cur_idx;
   assign touch_way = (state == FETCH) ? victim_r : hit_way;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         wc         <= '0;
         l_tag      <= '0;
         l_idx      <= '0;
         victim_r   <= '0;
         pend_inval <= 1'b0;
         iREN       <= 1'b0;
         iaddr      <= 32'd0;
         hitcnt     <= 32'd0;
         misscnt    <= 32'd0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            for (int w = 0; w < WAYS; w++) age[s][w] <= AW'(w);
         end
      end else begin
         if (ihit) hitcnt <= hitcnt + 32'd1;

         // True-LRU touch: the used way becomes youngest, younger ways age by one.
         if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AW'(w) == touch_way)
                  age[touch_set][w] <= '0;
               else if (age[touch_set][w] < age[touch_set][touch_way])
                  age[touch_set][w] <= age[touch_set][w] + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (inval) begin
                  for (int s = 0; s < SETS; s++) valid[s] <= '0;
               end else if (miss) begin
                  l_tag    <= cur_tag;
                  l_idx    <= cur_idx;
                  victim_r <= victim;
                  wc       <= '0;
                  iREN     <= 1'b1;
                  iaddr    <= 32'({cur_tag, cur_idx}) << (OB + 2);
                  misscnt  <= misscnt + 32'd1;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               if (fill_done) begin
                  if (pend_inval || inval) begin
                     for (int s = 0; s < SETS; s++) valid[s] <= '0;
                  end else begin
                     valid[l_idx][victim_r] <= 1'b1;
                  end
                  pend_inval <= 1'b0;
                  wc         <= '0;
                  iREN       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  if (inval) pend_inval <= 1'b1;
                  if (accept) begin
                     wc    <= wc + 1'b1;
                     iaddr <= iaddr + 32'd4;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: tag and data arrays are plain storage with no reset; the valid bits alone decide whether they are meaningful.
   always_ff @(posedge CLK) begin
      if (accept) data[l_idx][victim_r][wc] <= iload;
      if (fill_done) tags[l_idx][victim_r] <= l_tag;
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a responder models memory with configurable
// wait states, and expected fetch data is queued at request time.
module tb_icache_assoc;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        inval;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait = 1'b0;
   logic [31:0] iload = 32'd0;
   logic [31:0] hitcnt;
   logic [31:0] misscnt;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] acc_q[$];
   int          wait_n = 0;
   int          wcnt = 0;
   int          unstable = 0;
   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   icache_assoc #(.WAYS(2), .SETS(8), .BLKWORDS(2)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .inval(inval),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
      .iload(iload), .hitcnt(hitcnt), .misscnt(misscnt)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Memory responder: wait_n busy cycles precede every accepted word.
   always @(negedge CLK) begin
      if (iREN) begin
         if (prev_wait && iaddr !== prev_addr) unstable++;
         if (wcnt < wait_n) begin
            iwait = 1'b1;
            wcnt++;
         end else begin
            iwait = 1'b0;
            wcnt = 0;
            acc_q.push_back(iaddr);
         end
         prev_wait = iwait;
         prev_addr = iaddr;
      end else begin
         iwait = 1'b0;
         wcnt = 0;
         prev_wait = 1'b0;
      end
      iload = mem_word(iaddr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; holds the request until ihit, then drops it a cycle later.
   task automatic req(input logic [31:0] a, input int exp_cyc, input int inval_at, input string tag);
      int cyc;
      logic [31:0] exp_w;
      imemREN = 1'b1;
      imemaddr = a;
      exp_q.push_back(mem_word(a));
      cyc = 0;
      inval = (inval_at == 0);
      #1;
      while (ihit !== 1'b1 && cyc < 200) begin
         @(negedge CLK);
         cyc++;
         inval = (cyc == inval_at);
         #1;
      end
      inval = 1'b0;
      exp_w = exp_q.pop_front();
      check({tag, "_data"}, imemload, exp_w);
      check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_iren"}, {31'd0, iREN}, 32'd0);
      @(negedge CLK);
      imemREN = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      acc_q.delete();
      unstable = 0;
   endtask

   initial begin
      RST = 1'b1;
      imemREN = 1'b0;
      imemaddr = 32'd0;
      inval = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_ihit", {31'd0, ihit}, 32'd0);
      check("rst_load", imemload, 32'd0);
      check("rst_iren", {31'd0, iREN}, 32'd0);
      check("rst_iaddr", iaddr, 32'd0);
      check("rst_hitcnt", hitcnt, 32'd0);
      check("rst_misscnt", misscnt, 32'd0);
      RST = 1'b0;

      // Cold miss then hit on the neighbouring word of the same block
      req(32'h40, 3, -1, "cold");
      check("cold_nacc", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() == 2) begin
         check("cold_addr0", acc_q[0], 32'h40);
         check("cold_addr1", acc_q[1], 32'h44);
      end
      check("cold_misscnt", misscnt, 32'd1);
      req(32'h44, 0, -1, "warm");
      check("warm_hitcnt", hitcnt, 32'd2);

      // LRU eviction within set 0
      do_reset();
      req(32'h000, 3, -1, "ev_a");
      req(32'h040, 3, -1, "ev_b");
      req(32'h000, 0, -1, "ev_a_hit");
      req(32'h080, 3, -1, "ev_c");
      req(32'h000, 0, -1, "ev_a_kept");
      req(32'h040, 3, -1, "ev_b_gone");
      check("ev_misscnt", misscnt, 32'd4);
      check("ev_hitcnt", hitcnt, 32'd6);

      // Three wait cycles per word
      do_reset();
      wait_n = 3;
      req(32'h100, 9, -1, "wait");
      wait_n = 0;
      check("wait_stable", 32'(unstable), 32'd0);
      check("wait_nacc", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() == 2) begin
         check("wait_addr0", acc_q[0], 32'h100);
         check("wait_addr1", acc_q[1], 32'h104);
      end

      // Invalidate during the fill: line stays invalid, held request refetches
      do_reset();
      req(32'h100, 6, 1, "fill_inval");
      check("fill_inval_misscnt", misscnt, 32'd2);
      check("fill_inval_nacc", 32'(acc_q.size()), 32'd4);

      // Invalidate in IDLE after warm hits, then eviction order
      do_reset();
      req(32'h000, 3, -1, "iv_a");
      req(32'h040, 3, -1, "iv_b");
      req(32'h000, 0, -1, "iv_a_hit");
      req(32'h040, 0, -1, "iv_b_hit");
      req(32'h000, 4, 0, "iv_a_inval");
      req(32'h040, 3, -1, "iv_b_refill");
      req(32'h080, 3, -1, "iv_c");
      req(32'h040, 0, -1, "iv_b_kept");
      req(32'h000, 3, -1, "iv_a_gone");
      check("iv_misscnt", misscnt, 32'd6);
      check("iv_hitcnt", hitcnt, 32'd9);

      // Reset in the middle of a fill
      do_reset();
      imemREN = 1'b1;
      imemaddr = 32'h200;
      @(negedge CLK);
      #1;
      check("rstf_iren_before", {31'd0, iREN}, 32'd1);
      #1;
      RST = 1'b1;
      #1;
      check("rstf_iren", {31'd0, iREN}, 32'd0);
      check("rstf_misscnt", misscnt, 32'd0);
      check("rstf_hitcnt", hitcnt, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      acc_q.delete();
      req(32'h200, 3, -1, "rstf_after");
      check("rstf_after_misscnt", misscnt, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
